// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the pipeline stage register.
package pipe_pkg;

  // Default payload, control-bundle and performance-counter widths.
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_CTRL_W = 12;
  localparam int DEF_CNT_W  = 16;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing held
    HALF  = 2'd1,  // main entry holds the outgoing instruction
    FULL  = 2'd2   // main and skid entries both hold instructions
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stage's performance counters.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Count up on inc_i, holding at the all-ones ceiling instead of wrapping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register built as a two-entry skid buffer. ready_o is decoded
// from the registered state only, so the upstream ready path is fully timed
// from a flop. Also counts stall and bubble cycles for performance analysis.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // upstream side
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  // downstream side
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  // performance counters
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  pipe_state_e       state_q, state_d;

  logic [WIDTH-1:0]  main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

  logic              in_xfer, out_xfer;
  logic              load_main_in, load_main_skid, load_skid;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which always blocks execute.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush empties the buffer, otherwise track occupancy.
  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (in_xfer) state_d = HALF;
        HALF: begin
          if (in_xfer && !out_xfer) begin
            state_d = FULL;
          end else if (!in_xfer && out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_xfer) state_d = HALF;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output decode from registered state; a bubble never carries control bits.
  always_comb begin
    ready_o = (state_q != FULL);
    valid_o = (state_q != EMPTY);
    ctrl_o  = (state_q != EMPTY) ? main_ctrl_q : '0;
  end

  assign data_o = main_data_q;

  // Entry steering: decide which entry loads what this cycle. A flush drops
  // any incoming instruction and leaves the now-invalid entries untouched.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush_i) begin
      unique case (state_q)
        EMPTY: load_main_in = in_xfer;
        HALF: begin
          load_main_in = in_xfer & out_xfer;
          load_skid    = in_xfer & ~out_xfer;
        end
        FULL:    load_main_skid = out_xfer;
        default: ;
      endcase
    end
  end

  // Main entry: takes new data directly or the older item from the skid.
  // NOTE: payload registers are reset here because data_o must read zero
  // during reset; pure storage without that need could skip the reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (load_main_in) begin
      main_data_q <= data_i;
      main_ctrl_q <= ctrl_i;
    end else if (load_main_skid) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
  end

  // Skid entry: catches the instruction accepted while downstream stalls.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (load_skid) begin
      skid_data_q <= data_i;
      skid_ctrl_q <= ctrl_i;
    end
  end

  // Stall: holding a valid instruction that downstream refuses.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (valid_o & ~ready_i),
    .count_o (stall_cnt_o)
  );

  // Bubble: downstream ready but nothing to offer.
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (~valid_o & ready_i),
    .count_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_stage_reg;

  localparam int WIDTH  = 16;
  localparam int CTRL_W = 6;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [WIDTH-1:0]  data_i, data_o;
  logic [CTRL_W-1:0] ctrl_i, ctrl_o;
  logic [CNT_W-1:0]  stall_cnt_o, bubble_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .ctrl_i       (ctrl_i),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .ctrl_o       (ctrl_o),
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth two, oldest item on the output.
  typedef struct {
    logic [WIDTH-1:0]  d;
    logic [CTRL_W-1:0] c;
  } item_t;

  item_t mq[$];
  item_t m_new;
  int    m_stall = 0;
  int    m_bubble = 0;
  bit    m_acc, m_has;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      m_has = (mq.size() > 0);
      m_acc = valid_i && (mq.size() < 2);
      if (m_has && !ready_i && m_stall < CMAX) m_stall++;
      if (!m_has && ready_i && m_bubble < CMAX) m_bubble++;
      if (flush_i) begin
        mq.delete();
      end else begin
        if (m_has && ready_i) void'(mq.pop_front());
        if (m_acc) begin
          m_new.d = data_i;
          m_new.c = ctrl_i;
          mq.push_back(m_new);
        end
      end
    end
  end

  // Compare DUT against model mid-cycle, away from the active edge.
  always @(negedge clk_i) begin
    check("valid_o", valid_o, mq.size() > 0);
    check("ready_o", ready_o, mq.size() < 2);
    if (mq.size() > 0) begin
      check("data_o", data_o, mq[0].d);
      check("ctrl_o", ctrl_o, mq[0].c);
    end else begin
      check("ctrl_o_bubble", ctrl_o, 0);
    end
    check("stall_cnt_o", stall_cnt_o, m_stall);
    check("bubble_cnt_o", bubble_cnt_o, m_bubble);
  end

  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit rdy, input bit fl);
    valid_i = v;
    data_i  = d;
    ctrl_i  = d[CTRL_W-1:0] ^ 6'h15;
    ready_i = rdy;
    flush_i = fl;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    flush_i = 1'b0;
    data_i  = '0;
    ctrl_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_ready_o", ready_o, 1);
    check("rst_data_o", data_o, 0);
    check("rst_ctrl_o", ctrl_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_bubble", bubble_cnt_o, 0);

    // Single transfer right after reset: one-cycle latency.
    reset_i = 1'b0;
    step(1, 16'h00A5, 1, 0);
    check("lat_valid_o", valid_o, 1);
    check("lat_data_o", data_o, 16'h00A5);
    check("lat_ctrl_o", ctrl_o, 6'h25 ^ 6'h15);
    check("lat_bubble", bubble_cnt_o, 1);
    step(0, 0, 1, 0);
    check("drain_valid_o", valid_o, 0);

    // Backpressure: two accepted then stall; drain in order.
    step(1, 16'h1, 1, 0);
    check("bp_data1", data_o, 16'h1);
    step(1, 16'h2, 0, 0);
    check("bp_ready_low", ready_o, 0);
    check("bp_hold1", data_o, 16'h1);
    step(1, 16'h3, 0, 0);
    step(1, 16'h3, 0, 0);
    check("bp_stable", data_o, 16'h1);
    check("bp_stall3", stall_cnt_o, 3);
    step(1, 16'h3, 1, 0);
    check("bp_out2", data_o, 16'h2);
    check("bp_ready_back", ready_o, 1);
    step(1, 16'h3, 1, 0);
    check("bp_out3", data_o, 16'h3);
    step(1, 16'h4, 1, 0);
    check("bp_out4", data_o, 16'h4);
    step(0, 0, 1, 0);
    check("bp_empty", valid_o, 0);

    // Flush while FULL with a simultaneous input: everything discarded.
    step(1, 16'h10, 0, 0);
    step(1, 16'h11, 0, 0);
    check("fl_full", ready_o, 0);
    step(1, 16'h77, 0, 1);
    check("fl_valid_o", valid_o, 0);
    check("fl_ctrl_o", ctrl_o, 0);
    check("fl_ready_o", ready_o, 1);
    check("fl_stall5", stall_cnt_o, 5);
    step(0, 0, 1, 0);
    check("fl_no77", valid_o, 0);
    step(0, 0, 1, 0);

    // Stall counter saturation at 15.
    step(1, 16'h20, 0, 0);
    step(1, 16'h21, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    check("sat_stall", stall_cnt_o, 15);

    // Asynchronous reset between edges while FULL.
    #3 reset_i = 1'b1;
    #1;
    check("arst_valid_o", valid_o, 0);
    check("arst_data_o", data_o, 0);
    check("arst_ready_o", ready_o, 1);
    check("arst_stall", stall_cnt_o, 0);
    #1 reset_i = 1'b0;

    // Full throughput in HALF: one in, one out every cycle.
    step(1, 16'h30, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 16'(16'h30 + i), 1, 0);
      check("thr_data", data_o, 32'h30 + i);
      check("thr_ready", ready_o, 1);
      check("thr_valid", valid_o, 1);
    end
    check("thr_stall", stall_cnt_o, 0);
    step(0, 0, 1, 0);
    check("thr_empty", valid_o, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
